// File: rtl/display_scan.sv
// Time-multiplexed 7-segment scanner: walks the digit select, captures the BCD
// digit after the anti-ghost blank, and PWMs the one-hot digit enable.
module display_scan #(
    parameter int NUM_DIGITS   = 6,
    parameter int BLANK_CYCLES = 4,
    parameter int STEP_CYCLES  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_en,
    input  logic [2:0]            i_brightness,
    input  logic                  i_lz_blank,
    output logic [2:0]            o_seg_select,
    input  logic [3:0]            i_bcd,
    input  logic                  i_dp,
    output logic [6:0]            o_segments,
    output logic                  o_dp,
    output logic [NUM_DIGITS-1:0] o_digit_en
);

    localparam int SLOT_CYCLES = BLANK_CYCLES + 8 * STEP_CYCLES;
    localparam int CW          = $clog2(SLOT_CYCLES + 1);

    typedef enum logic [1:0] {ST_BLANK, ST_ON, ST_OFF} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              sel_q, sel_d;
    logic [2:0]              bright_q, bright_d;
    logic [6:0]              cap_seg_q, cap_seg_d;
    logic                    cap_dp_q, cap_dp_d;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   en_d;

    function automatic logic [6:0] decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Everything is computed for the counter value about to be entered, so the
    // registered outputs line up exactly with the cycle that holds that count.
    always_comb begin
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        bright_d  = bright_q;
        cap_seg_d = cap_seg_q;
        cap_dp_d  = cap_dp_q;
        state_d   = state_q;
        seg_d     = 7'h00;
        dp_d      = 1'b0;
        en_d      = '0;

        if (!i_en) begin
            cnt_d    = '0;
            sel_d    = 3'd0;
            bright_d = 3'd0;
            state_d  = ST_BLANK;
        end else begin
            if (cnt_q == '0)
                bright_d = i_brightness;

            if (cnt_q == CW'(SLOT_CYCLES - 1)) begin
                cnt_d = '0;
                sel_d = (sel_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : sel_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end

            // The selector has settled by the last blank cycle; grab the digit then.
            if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                cap_seg_d = (i_lz_blank && sel_q == 3'd0 && i_bcd == 4'd0) ? 7'h00 : decode(i_bcd);
                cap_dp_d  = i_dp;
            end

            if (int'(cnt_d) < BLANK_CYCLES)
                state_d = ST_BLANK;
            else if (int'(cnt_d) < BLANK_CYCLES + (int'(bright_d) + 1) * STEP_CYCLES)
                state_d = ST_ON;
            else
                state_d = ST_OFF;

            if (state_d == ST_ON) begin
                seg_d = cap_seg_d;
                dp_d  = cap_dp_d;
                en_d  = NUM_DIGITS'(1) << sel_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            sel_q        <= 3'd0;
            bright_q     <= 3'd0;
            cap_seg_q    <= 7'h00;
            cap_dp_q     <= 1'b0;
            o_segments   <= 7'h00;
            o_dp         <= 1'b0;
            o_digit_en   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            bright_q     <= bright_d;
            cap_seg_q    <= cap_seg_d;
            cap_dp_q     <= cap_dp_d;
            o_segments   <= seg_d;
            o_dp         <= dp_d;
            o_digit_en   <= en_d;
        end
    end

    assign o_seg_select = sel_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: reset, decode sweep, brightness PWM,
// frame wrap with blanking gaps, leading-zero blank, enable drop and async reset.
module tb_display_scan;

    logic       i_clk;
    logic       i_reset_n;
    logic       i_en;
    logic [2:0] i_brightness;
    logic       i_lz_blank;
    logic [2:0] o_seg_select;
    logic [3:0] i_bcd;
    logic       i_dp;
    logic [6:0] o_segments;
    logic       o_dp;
    logic [5:0] o_digit_en;

    int checks   = 0;
    int failures = 0;

    // Reference state: slot counter, digit, latched brightness, captured digit
    int         tc;
    int         tsel;
    int         mb;
    logic [6:0] mseg;
    logic       mdp;
    int         zero_run;
    logic [5:0] last_en;

    logic [6:0] seg_tab [16];

    display_scan dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_en         (i_en),
        .i_brightness (i_brightness),
        .i_lz_blank   (i_lz_blank),
        .o_seg_select (o_seg_select),
        .i_bcd        (i_bcd),
        .i_dp         (i_dp),
        .o_segments   (o_segments),
        .o_dp         (o_dp),
        .o_digit_en   (o_digit_en)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [2:0] br, input logic lz,
                                 input logic [3:0] bcd, input logic dp);
        i_en         = en;
        i_brightness = br;
        i_lz_blank   = lz;
        i_bcd        = bcd;
        i_dp         = dp;
    endtask

    task automatic checkModel();
        logic       lit;
        logic [5:0] exp_en;
        lit    = (tc >= 4) && (tc < 4 + (mb + 1) * 4);
        exp_en = lit ? (6'(1) << tsel) : 6'd0;
        checkOutput("model_sel", 32'(o_seg_select), 32'(tsel));
        checkOutput("model_en", 32'(o_digit_en), 32'(exp_en));
        checkOutput("model_seg", 32'(o_segments), lit ? 32'(mseg) : 32'd0);
        checkOutput("model_dp", 32'(o_dp), lit ? 32'(mdp) : 32'd0);
        checkOutput("onehot", 32'($countones(o_digit_en) <= 1), 32'd1);
        if (o_digit_en == 6'd0) begin
            zero_run++;
        end else begin
            if (last_en != 6'd0 && o_digit_en != last_en)
                checkOutput("blank_gap", 32'(zero_run >= 4), 32'd1);
            zero_run = 0;
            last_en  = o_digit_en;
        end
    endtask

    task automatic tick();
        logic       en_v;
        logic [2:0] br_v;
        logic       lz_v;
        logic [3:0] bcd_v;
        logic       dp_v;
        en_v  = i_en;
        br_v  = i_brightness;
        lz_v  = i_lz_blank;
        bcd_v = i_bcd;
        dp_v  = i_dp;
        @(posedge i_clk);
        if (!en_v) begin
            tc   = 0;
            tsel = 0;
            mb   = 0;
        end else begin
            if (tc == 0)
                mb = int'(br_v);
            if (tc == 3) begin
                mseg = (lz_v && tsel == 0 && bcd_v == 4'd0) ? 7'h00 : seg_tab[bcd_v];
                mdp  = dp_v;
            end
            if (tc == 35) begin
                tc   = 0;
                tsel = (tsel == 5) ? 0 : tsel + 1;
            end else begin
                tc++;
            end
        end
        @(negedge i_clk);
        checkModel();
    endtask

    task automatic resetModel();
        tc       = 0;
        tsel     = 0;
        mb       = 0;
        mseg     = 7'h00;
        mdp      = 1'b0;
        zero_run = 0;
        last_en  = 6'd0;
    endtask

    initial begin
        int first_on;
        int last_on;
        int lit_cnt;

        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        resetModel();

        // Reset held three cycles with a live digit on the inputs
        i_reset_n = 1'b0;
        applyStimulus(1'b1, 3'd7, 1'b0, 4'd8, 1'b0);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("reset_sel", 32'(o_seg_select), 32'd0);
        checkOutput("reset_seg", 32'(o_segments), 32'd0);
        checkOutput("reset_dp", 32'(o_dp), 32'd0);
        checkOutput("reset_en", 32'(o_digit_en), 32'd0);
        i_reset_n = 1'b1;

        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 3)  checkOutput("rst_c3_en", 32'(o_digit_en), 32'd0);
            if (k == 4)  checkOutput("rst_c4_en", 32'(o_digit_en), 32'b000001);
            if (k == 4)  checkOutput("rst_c4_seg", 32'(o_segments), 32'h7F);
            if (k == 35) checkOutput("rst_c35_en", 32'(o_digit_en), 32'b000001);
            if (k == 36) checkOutput("rst_c36_sel", 32'(o_seg_select), 32'd1);
            if (k == 36) checkOutput("rst_c36_en", 32'(o_digit_en), 32'd0);
        end

        // Decode sweep, one BCD value per slot
        for (int v = 0; v < 16; v++) begin
            logic [3:0] vb;
            vb = 4'(v);
            applyStimulus(1'b1, 3'd7, 1'b0, vb, vb[0]);
            for (int k = 1; k <= 36; k++) begin
                tick();
                if (k == 4) begin
                    checkOutput($sformatf("decode_seg_%0d", v), 32'(o_segments), 32'(seg_tab[v]));
                    checkOutput($sformatf("decode_dp_%0d", v), 32'(o_dp), 32'(vb[0]));
                end
            end
        end

        // Brightness 0 on digit 5, then 3 on digit 0, then 3->7 mid-slot
        applyStimulus(1'b1, 3'd0, 1'b0, 4'd2, 1'b0);
        first_on = -1; last_on = -1; lit_cnt = 0;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (o_digit_en != 6'd0) begin
                if (first_on < 0) first_on = k;
                last_on = k;
                lit_cnt++;
            end
        end
        checkOutput("b0_first", 32'(first_on), 32'd4);
        checkOutput("b0_last", 32'(last_on), 32'd7);
        checkOutput("b0_count", 32'(lit_cnt), 32'd4);

        applyStimulus(1'b1, 3'd3, 1'b0, 4'd3, 1'b0);
        first_on = -1; last_on = -1; lit_cnt = 0;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (o_digit_en != 6'd0) begin
                if (first_on < 0) first_on = k;
                last_on = k;
                lit_cnt++;
            end
        end
        checkOutput("b3_first", 32'(first_on), 32'd4);
        checkOutput("b3_last", 32'(last_on), 32'd19);
        checkOutput("b3_count", 32'(lit_cnt), 32'd16);

        last_on = -1;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 10) applyStimulus(1'b1, 3'd7, 1'b0, 4'd3, 1'b0);
            if (o_digit_en != 6'd0) last_on = k;
        end
        checkOutput("b3to7_last", 32'(last_on), 32'd19);

        lit_cnt = 0;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (o_digit_en != 6'd0) lit_cnt++;
            if (k == 35) checkOutput("b7_c35_en", 32'(o_digit_en), 32'b000100);
        end
        checkOutput("b7_count", 32'(lit_cnt), 32'd32);

        // Two full frames starting from digit 3
        for (int j = 1; j <= 432; j++) begin
            if ((j - 1) % 36 == 0)
                applyStimulus(1'b1, 3'd7, 1'b0, 4'(((j - 1) / 36) % 10), 1'b0);
            tick();
            if (j % 36 == 4)
                checkOutput($sformatf("wrap_sel_%0d", j / 36), 32'(o_seg_select), 32'((3 + j / 36) % 6));
        end

        // Enable drop at digit 3, c=20
        for (int k = 1; k <= 20; k++) tick();
        checkOutput("pre_drop_en", 32'(o_digit_en), 32'b001000);
        applyStimulus(1'b0, 3'd7, 1'b0, 4'd5, 1'b0);
        tick();
        checkOutput("drop_en", 32'(o_digit_en), 32'd0);
        checkOutput("drop_sel", 32'(o_seg_select), 32'd0);
        checkOutput("drop_seg", 32'(o_segments), 32'd0);
        repeat (3) tick();
        checkOutput("held_en", 32'(o_digit_en), 32'd0);

        // Re-enable straight into a leading-zero digit 0
        applyStimulus(1'b1, 3'd7, 1'b1, 4'd0, 1'b1);
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 4) begin
                checkOutput("lz_sel", 32'(o_seg_select), 32'd0);
                checkOutput("lz_seg", 32'(o_segments), 32'd0);
                checkOutput("lz_dp", 32'(o_dp), 32'd1);
                checkOutput("lz_en", 32'(o_digit_en), 32'b000001);
            end
        end
        applyStimulus(1'b1, 3'd7, 1'b1, 4'd0, 1'b0);
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 4) checkOutput("lz_other_digit", 32'(o_segments), 32'h3F);
        end
        repeat (4 * 36) tick();
        applyStimulus(1'b1, 3'd7, 1'b1, 4'd1, 1'b0);
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 4) checkOutput("lz_one_seg", 32'(o_segments), 32'h06);
        end

        // Asynchronous reset in the middle of an ON phase
        for (int k = 1; k <= 10; k++) tick();
        checkOutput("pre_areset_en", 32'(o_digit_en), 32'b000010);
        #2 i_reset_n = 1'b0;
        #1;
        checkOutput("areset_en", 32'(o_digit_en), 32'd0);
        checkOutput("areset_seg", 32'(o_segments), 32'd0);
        checkOutput("areset_sel", 32'(o_seg_select), 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        resetModel();
        for (int k = 1; k <= 6; k++) tick();
        checkOutput("post_areset_en", 32'(o_digit_en), 32'b000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
